// File: rtl/mux_rr_reg_pkg.sv
// Shared definitions for the registered round-robin/direct channel selector.
// Grant-mode encodings and the round-robin pointer advance rule.
package mux_rr_reg_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // Pointer moves just past the granted channel, wrapping at nch.
  function automatic int rr_next(input int gnt, input int nch);
    int nxt;
    if (gnt == nch - 1) begin
      nxt = 0;
    end else begin
      nxt = gnt + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mux_rr_reg_if.sv
// Source-side and consumer-side handshake bundle of the channel selector.
// The slave modport is the selector; the master modport is the surrounding datapath.
interface mux_rr_reg_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_rr_reg_rr_arb.sv
// Combinational rotate-priority encoder: first requester at or after ptr, wrapping.
// ptr is assumed to be below NCH.
module rr_arb #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt,
  output logic            gnt_v
);

  logic [SELW:0] pos_s;

  // Walk offsets from farthest to nearest so the requester closest to ptr is written last.
  always_comb begin
    gnt   = '0;
    gnt_v = 1'b0;
    pos_s = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      pos_s = {1'b0, ptr} + (SELW + 1)'(k);
      if (pos_s >= (SELW + 1)'(NCH)) begin
        pos_s = pos_s - (SELW + 1)'(NCH);
      end else begin
        pos_s = pos_s;
      end
      if (req[pos_s[SELW-1:0]]) begin
        gnt   = pos_s[SELW-1:0];
        gnt_v = 1'b1;
      end else begin
        gnt   = gnt;
        gnt_v = gnt_v;
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// NCH-channel registered selector with valid/ready handshake and a direct or
// round-robin grant; one output register stage between sources and consumer.
module mux_rr_reg
  import mux_rr_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input logic         clk,
  input logic         rst,
  mux_rr_reg_if.slave bus
);

  localparam int NSEL = 1 << SELW;

  logic [SELW-1:0]  rr_ptr_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_ch_r;
  logic             out_valid_r;

  logic [SELW-1:0]  rr_gnt_s;
  logic             rr_gnt_v_s;
  logic [NSEL-1:0]  valid_ext_s;
  logic             sel_ok_s;
  logic [SELW-1:0]  gnt_s;
  logic             gnt_v_s;
  logic             ld_s;
  logic             xfer_s;
  logic [NCH-1:0]   ready_s;
  logic [WIDTH-1:0] sel_data_s;

  rr_arb #(.NCH(NCH), .SELW(SELW)) u_rr_arb (
    .req   (bus.in_valid),
    .ptr   (rr_ptr_r),
    .gnt   (rr_gnt_s),
    .gnt_v (rr_gnt_v_s)
  );

  // Zero-extended valids keep an out-of-range direct select from reading past NCH.
  assign valid_ext_s = NSEL'(bus.in_valid);
  assign sel_ok_s    = ({1'b0, bus.sel} < (SELW + 1)'(NCH));
  assign ld_s        = !out_valid_r || bus.out_ready;
  assign xfer_s      = ld_s && gnt_v_s;

  // Grant source: external select in direct mode, arbiter in round-robin mode.
  always_comb begin
    if (bus.mode == MODE_RR) begin
      gnt_s   = rr_gnt_s;
      gnt_v_s = rr_gnt_v_s;
    end else begin
      gnt_s   = bus.sel;
      gnt_v_s = sel_ok_s && valid_ext_s[bus.sel];
    end
  end

  // Ready fan-out and data select; neither depends on the data itself.
  always_comb begin
    ready_s    = '0;
    sel_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      ready_s[i] = xfer_s && (gnt_s == SELW'(i));
      if (gnt_s == SELW'(i)) begin
        sel_data_s = bus.in_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Output register and round-robin pointer; a load takes priority over a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
      rr_ptr_r    <= '0;
    end else if (xfer_s) begin
      out_data_r  <= sel_data_s;
      out_ch_r    <= gnt_s;
      out_valid_r <= 1'b1;
      if (bus.mode == MODE_RR) begin
        rr_ptr_r <= SELW'(rr_next(int'(gnt_s), NCH));
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: directed scenarios then random traffic on a 4-channel and
// a 3-channel instance, both compared against a behavioural model of the selector.
module tb_mux_rr_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_reg_if #(.WIDTH(32), .NCH(4), .SELW(2)) ifa ();
  mux_rr_reg_if #(.WIDTH(32), .NCH(3), .SELW(2)) ifb ();

  mux_rr_reg #(.WIDTH(32), .NCH(4), .SELW(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mux_rr_reg #(.WIDTH(32), .NCH(3), .SELW(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int total = 0;
  int bad   = 0;

  logic [31:0] s_data [2][4];
  logic [3:0]  s_valid [2];
  logic [1:0]  s_sel [2];
  logic        s_mode [2];
  logic        s_ordy [2];

  bit          m_valid [2];
  logic [31:0] m_data [2];
  int          m_ch [2];
  int          m_ptr [2];
  int          x_g [2];
  bit          x_go [2];
  int          nch [2] = '{4, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = 32'h0;
      m_ch[d]    = 0;
      m_ptr[d]   = 0;
      x_go[d]    = 1'b0;
      x_g[d]     = 0;
    end
  endtask

  task automatic drive();
    ifa.in_data   = {s_data[0][3], s_data[0][2], s_data[0][1], s_data[0][0]};
    ifa.in_valid  = s_valid[0];
    ifa.sel       = s_sel[0];
    ifa.mode      = s_mode[0];
    ifa.out_ready = s_ordy[0];
    ifb.in_data   = {s_data[1][2], s_data[1][1], s_data[1][0]};
    ifb.in_valid  = s_valid[1][2:0];
    ifb.sel       = s_sel[1];
    ifb.mode      = s_mode[1];
    ifb.out_ready = s_ordy[1];
  endtask

  // Which channel the selector should be offering, straight from the grant rules.
  function automatic void grant(input int d, output int g, output bit gv);
    g  = 0;
    gv = 1'b0;
    if (s_mode[d] == 1'b0) begin
      g  = int'(s_sel[d]);
      gv = (g < nch[d]) && s_valid[d][g];
    end else begin
      for (int k = 0; k < nch[d]; k++) begin
        int i;
        i = (m_ptr[d] + k) % nch[d];
        if (!gv && s_valid[d][i]) begin
          g  = i;
          gv = 1'b1;
        end
      end
    end
  endfunction

  task automatic step();
    logic [3:0] exp_rdy;
    logic [3:0] obs_rdy;
    bit         ld;
    string      nm;
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "A" : "B";
      grant(d, x_g[d], x_go[d]);
      ld      = !m_valid[d] || s_ordy[d];
      x_go[d] = x_go[d] && ld;
      exp_rdy = x_go[d] ? 4'(1 << x_g[d]) : 4'b0000;
      obs_rdy = (d == 0) ? ifa.in_ready : {1'b0, ifb.in_ready};
      chk({nm, ".in_ready"}, 64'(obs_rdy), 64'(exp_rdy));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "A" : "B";
      if (x_go[d]) begin
        m_valid[d] = 1'b1;
        m_data[d]  = s_data[d][x_g[d]];
        m_ch[d]    = x_g[d];
        if (s_mode[d]) m_ptr[d] = (x_g[d] + 1) % nch[d];
      end else if (m_valid[d] && s_ordy[d]) begin
        m_valid[d] = 1'b0;
      end
      chk({nm, ".out_valid"}, 64'((d == 0) ? ifa.out_valid : ifb.out_valid), 64'(m_valid[d]));
      chk({nm, ".out_data"},  64'((d == 0) ? ifa.out_data  : ifb.out_data),  64'(m_data[d]));
      chk({nm, ".out_ch"},    64'((d == 0) ? ifa.out_ch    : ifb.out_ch),    64'(m_ch[d]));
    end
  endtask

  // New words only replace ones that were accepted or absent; pending ones are held.
  task automatic rand_stim();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < nch[d]; ch++) begin
        if (!s_valid[d][ch] || (x_go[d] && x_g[d] == ch)) begin
          s_valid[d][ch] = 1'($urandom_range(0, 1));
          s_data[d][ch]  = $urandom;
        end
      end
      s_ordy[d] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) s_mode[d] = 1'($urandom_range(0, 1));
      s_sel[d] = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) s_data[d][ch] = 32'h1000_0000 + 32'(ch) + 32'(d * 16);
      s_valid[d] = 4'b0000;
      s_sel[d]   = 2'd0;
      s_mode[d]  = 1'b0;
      s_ordy[d]  = 1'b0;
    end
    model_reset();
    rst = 1'b1;
    drive();
    #12;
    chk("rst.A.out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst.A.out_data",  64'(ifa.out_data),  64'd0);
    chk("rst.A.out_ch",    64'(ifa.out_ch),    64'd0);
    chk("rst.B.out_valid", 64'(ifb.out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // direct select of channel 2
    s_sel[0] = 2'd2; s_valid[0] = 4'b0100; s_data[0][2] = 32'hDEADBEEF; s_ordy[0] = 1'b1;
    step();
    chk("t2.out_data",  64'(ifa.out_data),  64'hDEADBEEF);
    chk("t2.out_ch",    64'(ifa.out_ch),    64'd2);
    chk("t2.out_valid", 64'(ifa.out_valid), 64'd1);

    // direct select of an idle channel while others are valid
    s_sel[0] = 2'd1; s_valid[0] = 4'b1101;
    step();
    chk("t3.drain", 64'(ifa.out_valid), 64'd0);
    step();
    chk("t3.idle", 64'(ifa.out_valid), 64'd0);

    // reset with a word held in the output register
    s_mode[0] = 1'b1; s_valid[0] = 4'b0001; s_ordy[0] = 1'b0;
    step();
    chk("t1.held", 64'(ifa.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t1.out_valid", 64'(ifa.out_valid), 64'd0);
    chk("t1.out_data",  64'(ifa.out_data),  64'd0);
    chk("t1.out_ch",    64'(ifa.out_ch),    64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // round-robin fairness, starting from channel 0 after reset
    s_data[0][2] = 32'h1000_0002;
    s_valid[0] = 4'b1111; s_ordy[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4.rr_seq", 64'(ifa.out_ch), 64'(k % 4));
    end
    s_valid[0] = 4'b1001;
    step();
    chk("t4.wrap_hi", 64'(ifa.out_ch), 64'd3);
    step();
    chk("t4.wrap_lo", 64'(ifa.out_ch), 64'd0);

    // backpressure then release with no bubble
    s_ordy[0] = 1'b0; s_valid[0] = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5.stall_data", 64'(ifa.out_data), 64'(s_data[0][0]));
      chk("t5.stall_rdy",  64'(ifa.in_ready), 64'd0);
    end
    s_ordy[0] = 1'b1;
    step();
    chk("t5.resume_ch",    64'(ifa.out_ch),    64'd1);
    chk("t5.resume_valid", 64'(ifa.out_valid), 64'd1);
    chk("t5.resume_data",  64'(ifa.out_data),  64'(s_data[0][1]));

    // 3-channel instance: out-of-range select, then RR resumes from retained pointer
    s_valid[0] = 4'b0000;
    s_mode[1] = 1'b1; s_valid[1] = 4'b0111; s_ordy[1] = 1'b1;
    step();
    chk("t6.rr0", 64'(ifb.out_ch), 64'd0);
    step();
    chk("t6.rr1", 64'(ifb.out_ch), 64'd1);
    s_mode[1] = 1'b0; s_sel[1] = 2'd3;
    step();
    chk("t6.oor_rdy",   64'(ifb.in_ready),  64'd0);
    chk("t6.oor_valid", 64'(ifb.out_valid), 64'd0);
    chk("t6.oor_data",  64'(ifb.out_data),  64'(s_data[1][1]));
    s_mode[1] = 1'b1;
    step();
    chk("t6.resume_ch", 64'(ifb.out_ch), 64'd2);

    // random traffic on both instances
    for (int n = 0; n < 400; n++) begin
      rand_stim();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
